eth_rx_frame_fifo: RTL and testbench
====================================

ETH_RX_FRAME_FIFO -- requirements
Module: eth_rx_frame_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 512, FIFO depth in beats; power of two, 16..4096.
REQ-002 SHALL take N_SYMBOLS (8) and W_SYMBOL (8) from cmn_params; beat = N_SYMBOLS x W_SYMBOL data bits.
REQ-003 SHALL have ports:
- i_clk  in  1  sole clock, the MAC RX clock domain.
- i_reset_n  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  1  beat from MAC RX; no backpressure, no tready port.
- s_axis_tdata  in  N_SYMBOLS x W_SYMBOL  beat data.
- s_axis_tkeep  in  N_SYMBOLS  byte enables.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tuser  in  1  frame error flag, meaningful only with tlast.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tdata  out  N_SYMBOLS x W_SYMBOL  output data.
- m_axis_tkeep  out  N_SYMBOLS  output byte enables.
- m_axis_tlast  out  1  output last beat.
- m_axis_tready  in  1  downstream ready.
- o_frame_cnt  out  16  committed-frame count, wraps.
- o_drop_cnt  out  16  dropped-frame count, saturates at 0xFFFF.
- o_drop  out  1  one-cycle pulse per dropped frame.

Function
REQ-004 SHALL be store-and-forward: no beat of a frame appears on m_axis before its tlast beat is accepted and committed.
REQ-005 SHALL keep pointers of log2(DEPTH)+1 bits: wr_ptr, wr_commit, rd_ptr; wrap is natural binary overflow.
REQ-006 SHALL define full = (wr_ptr - rd_ptr) == DEPTH, from registered pointers; same-cycle reads do not free space for the write.
REQ-007 SHALL run a write FSM with states IDLE, FRAME, DROP.
REQ-008 IDLE: valid beat, not full -> write, wr_ptr+1; tlast -> end-of-frame handling, stay IDLE; else -> FRAME.
REQ-009 FRAME: valid beat, not full -> write; on tlast -> end-of-frame handling, -> IDLE.
REQ-010 End-of-frame: tuser=0 -> wr_commit <= wr_ptr+1, o_frame_cnt+1; tuser=1 -> wr_ptr <= wr_commit, drop.
REQ-011 Valid beat while full (IDLE or FRAME): wr_ptr <= wr_commit, drop; tlast on that beat -> IDLE, else -> DROP.
REQ-012 DROP: discard all beats; tlast -> IDLE; no further drop event for that frame.
REQ-013 Drop event SHALL assert o_drop one cycle and increment o_drop_cnt (saturating), exactly once per frame.
REQ-014 Frames longer than DEPTH beats SHALL always be dropped per REQ-011.
REQ-015 s_axis_tvalid=0 cycles SHALL not change FSM state or pointers.
REQ-016 Read side SHALL present beats from rd_ptr while rd_ptr != wr_commit, via a registered output stage fed from synchronous-read RAM.
REQ-017 A beat SHALL transfer when m_axis_tvalid and m_axis_tready are both high; m_axis_* SHALL hold stable while tvalid=1 and tready=0.
REQ-018 With output empty and tready=1, first beat SHALL show m_axis_tvalid=1 exactly 2 cycles after the clock edge sampling the committing tlast beat.
REQ-019 With tready held high, committed data SHALL stream one beat per cycle without bubbles, across frame boundaries.
REQ-020 Rollbacks SHALL never move wr_ptr below wr_commit nor affect beats already committed or in flight on m_axis.
REQ-021 tdata, tkeep, tlast SHALL be reproduced bit-exact; tuser is not stored.

Reset
REQ-022 i_reset_n low SHALL immediately force: all pointers 0, FSM IDLE, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata/tkeep 0, o_drop 0, o_frame_cnt 0, o_drop_cnt 0.
REQ-023 Reset mid-frame SHALL discard all stored and partial frames; after release, beats until the next frame start SHALL be written as a new frame (upstream guarantees frame alignment after reset).
REQ-024 RAM contents need not be reset.

Verification
REQ-025 Single 8-beat frame, tuser=0, tready=1 -> tvalid rises 2 cycles after tlast sampled; 8 identical beats out; o_frame_cnt=1.
REQ-026 Frame tuser=1 on tlast then good 4-beat frame -> o_drop pulse, o_drop_cnt=1; only the 4-beat frame appears on m_axis.
REQ-027 DEPTH=16, tready=0, 10-beat good frame then 10-beat frame -> second dropped on 7th beat, o_drop_cnt=1; release tready -> only first frame out.
REQ-028 20-beat frame with DEPTH=16, output idle -> dropped, nothing on m_axis, FSM in DROP until tlast.
REQ-029 Random tready toggling over 1000 random good frames -> output data matches scoreboard, m_axis stable while stalled, o_frame_cnt=1000 mod 65536.
REQ-030 Assert i_reset_n low mid-output -> m_axis_tvalid 0 asynchronously; counters 0; next frame after release passes intact.

Source files
------------

// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo: store-and-forward RX frame FIFO for the MAC clock domain.
// Errored or overflowing frames are rolled back to the last commit point.
package cmn_params;
  localparam int N_SYMBOLS = 8;
  localparam int W_SYMBOL  = 8;
endpackage

module eth_rx_frame_fifo
  import cmn_params::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          s_axis_tvalid,
  input  logic [N_SYMBOLS*W_SYMBOL-1:0] s_axis_tdata,
  input  logic [N_SYMBOLS-1:0]          s_axis_tkeep,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tuser,
  output logic                          m_axis_tvalid,
  output logic [N_SYMBOLS*W_SYMBOL-1:0] m_axis_tdata,
  output logic [N_SYMBOLS-1:0]          m_axis_tkeep,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [15:0]                   o_frame_cnt,
  output logic [15:0]                   o_drop_cnt,
  output logic                          o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = N_SYMBOLS * W_SYMBOL;

  typedef struct packed {
    logic                 last;
    logic [N_SYMBOLS-1:0] keep;
    logic [DW-1:0]        data;
  } beat_t;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    DROP
  } wr_state_t;

  typedef logic [AW:0] ptr_t;

  wr_state_t state;
  ptr_t      wr_ptr;
  ptr_t      wr_commit;
  ptr_t      rd_ptr;
  ptr_t      fetch_ptr;

  beat_t mem [DEPTH];
  beat_t beat_in;
  beat_t ram_q;
  logic  s1_vld;

  logic full;
  logic wr_en;
  logic commit;
  logic drop_evt;
  logic out_adv;
  logic fetch;
  logic xfer;

  assign beat_in = '{
    last: s_axis_tlast,
    keep: s_axis_tkeep,
    data: s_axis_tdata
  };

  // rd_ptr only advances on an m_axis handshake, so beats still in the
  // output pipeline keep their RAM slots reserved.
  assign full = (wr_ptr - rd_ptr) == ptr_t'(DEPTH);

  assign wr_en = s_axis_tvalid && !full
              && (state != DROP);

  assign commit = wr_en && s_axis_tlast
               && !s_axis_tuser;

  assign drop_evt = s_axis_tvalid && (state != DROP)
                 && (full || (s_axis_tlast && s_axis_tuser));

  assign out_adv = !m_axis_tvalid || m_axis_tready;
  assign xfer    = m_axis_tvalid && m_axis_tready;
  assign fetch   = (fetch_ptr != wr_commit)
                && (!s1_vld || out_adv);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      wr_commit   <= '0;
      o_frame_cnt <= '0;
      o_drop_cnt  <= '0;
      o_drop      <= 1'b0;
    end else begin
      o_drop <= drop_evt;
      if (drop_evt && o_drop_cnt != 16'hFFFF)
        o_drop_cnt <= o_drop_cnt + 16'd1;
      if (commit)
        o_frame_cnt <= o_frame_cnt + 16'd1;
      if (s_axis_tvalid) begin
        unique case (state)
          IDLE, FRAME: begin
            if (full) begin
              wr_ptr <= wr_commit;
              state  <= s_axis_tlast ? IDLE : DROP;
            end else if (!s_axis_tlast) begin
              wr_ptr <= wr_ptr + 1'b1;
              state  <= FRAME;
            end else if (s_axis_tuser) begin
              wr_ptr <= wr_commit;
              state  <= IDLE;
            end else begin
              wr_ptr    <= wr_ptr + 1'b1;
              wr_commit <= wr_ptr + 1'b1;
              state     <= IDLE;
            end
          end
          DROP: begin
            if (s_axis_tlast)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= beat_in;
    if (fetch)
      ram_q <= mem[fetch_ptr[AW-1:0]];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fetch_ptr     <= '0;
      rd_ptr        <= '0;
      s1_vld        <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (fetch) begin
        fetch_ptr <= fetch_ptr + 1'b1;
        s1_vld    <= 1'b1;
      end else if (s1_vld && out_adv) begin
        s1_vld <= 1'b0;
      end
      if (xfer)
        rd_ptr <= rd_ptr + 1'b1;
      if (out_adv) begin
        m_axis_tvalid <= s1_vld;
        if (s1_vld) begin
          m_axis_tdata <= ram_q.data;
          m_axis_tkeep <= ram_q.keep;
          m_axis_tlast <= ram_q.last;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// tb_eth_rx_frame_fifo: directed and paced-random checks of the RX frame FIFO
// against a queue model of committed frames and FIFO occupancy.
module tb_eth_rx_frame_fifo;
  import cmn_params::*;

  localparam int DEPTH = 16;
  localparam int DW    = N_SYMBOLS * W_SYMBOL;

  typedef struct packed {
    logic [DW-1:0]        d;
    logic [N_SYMBOLS-1:0] k;
    logic                 l;
  } bt_t;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 s_axis_tvalid;
  logic [DW-1:0]        s_axis_tdata;
  logic [N_SYMBOLS-1:0] s_axis_tkeep;
  logic                 s_axis_tlast;
  logic                 s_axis_tuser;
  logic                 m_axis_tvalid;
  logic [DW-1:0]        m_axis_tdata;
  logic [N_SYMBOLS-1:0] m_axis_tkeep;
  logic                 m_axis_tlast;
  logic                 m_axis_tready;
  logic [15:0]          o_frame_cnt;
  logic [15:0]          o_drop_cnt;
  logic                 o_drop;

  eth_rx_frame_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .o_frame_cnt   (o_frame_cnt),
    .o_drop_cnt    (o_drop_cnt),
    .o_drop        (o_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Model: committed-but-not-transferred beats, the open frame, counters.
  bt_t         exp_q[$];
  bt_t         part_q[$];
  bit          dropping = 0;
  logic [15:0] m_frame  = '0;
  logic [15:0] m_dcnt   = '0;
  logic        m_drop   = 1'b0;
  int          xfers    = 0;
  bit          m_full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      part_q.delete();
      dropping = 0;
      m_frame  = '0;
      m_dcnt   = '0;
      m_drop   = 1'b0;
    end else begin
      m_full = (exp_q.size() + part_q.size()) == DEPTH;
      if (m_axis_tvalid && m_axis_tready) begin
        xfers++;
        if (exp_q.size() != 0)
          void'(exp_q.pop_front());
      end
      m_drop = 1'b0;
      if (s_axis_tvalid) begin
        if (dropping) begin
          if (s_axis_tlast)
            dropping = 0;
        end else if (m_full) begin
          part_q.delete();
          m_drop   = 1'b1;
          dropping = !s_axis_tlast;
        end else begin
          part_q.push_back('{s_axis_tdata, s_axis_tkeep, s_axis_tlast});
          if (s_axis_tlast && s_axis_tuser) begin
            m_drop = 1'b1;
            part_q.delete();
          end else if (s_axis_tlast) begin
            foreach (part_q[i])
              exp_q.push_back(part_q[i]);
            part_q.delete();
            m_frame = m_frame + 16'd1;
          end
        end
      end
      if (m_drop && m_dcnt != 16'hFFFF)
        m_dcnt = m_dcnt + 16'd1;
    end
  end

  bt_t cur;
  bt_t pb;
  bit  pv = 0;
  bit  pr = 0;

  assign cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 0;
    end else begin
      check("frame_cnt", 128'(o_frame_cnt), 128'(m_frame));
      check("drop_cnt", 128'(o_drop_cnt), 128'(m_dcnt));
      check("drop_pulse", 128'(o_drop), 128'(m_drop));
      if (pv && !pr)
        check("stall_hold", 128'({m_axis_tvalid, cur}), 128'({1'b1, pb}));
      if (m_axis_tvalid) begin
        check("valid_has_data", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0)
          check("out_beat", 128'(cur), 128'(exp_q[0]));
      end
      pv = m_axis_tvalid;
      pr = m_axis_tready;
      pb = cur;
    end
  end

  bit rnd_ready = 0;

  task automatic tick();
    if (rnd_ready)
      m_axis_tready = ($urandom_range(0, 9) < 7);
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] d,
                      input logic [N_SYMBOLS-1:0] k,
                      input logic l,
                      input logic u);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  function automatic logic [DW-1:0] mk(input int f, input int i);
    return {16'(f), 16'hC0DE, 16'h0000, 16'(i)};
  endfunction

  task automatic frame(input int f, input int n, input logic u);
    for (int i = 0; i < n; i++)
      beat(mk(f, i), 8'hFF, i == n - 1, u && (i == n - 1));
  endtask

  task automatic drain();
    int t;
    t = 0;
    rnd_ready = 0;
    m_axis_tready = 1'b1;
    while ((exp_q.size() != 0 || m_axis_tvalid) && t < 300) begin
      tick();
      t++;
    end
    check("drain_done", 128'(exp_q.size() != 0 || m_axis_tvalid), 128'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("rst_tlast", 128'(m_axis_tlast), 128'(0));
    check("rst_tdata", 128'({m_axis_tdata, m_axis_tkeep}), 128'(0));
    check("rst_drop", 128'(o_drop), 128'(0));
    check("rst_cnts", 128'({o_frame_cnt, o_drop_cnt}), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int x0;
    int t;
    int vcnt;
    int n;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    m_axis_tready = 1'b1;
    #2;
    do_reset();

    // Latency and bubble-free streaming across a frame boundary.
    m_axis_tready = 1'b1;
    frame(1, 8, 1'b0);
    check("t1_frame_cnt", 128'(o_frame_cnt), 128'(1));
    beat(mk(2, 0), 8'hFF, 1'b0, 1'b0);
    check("t1_lat_e1", 128'(m_axis_tvalid), 128'(0));
    beat(mk(2, 1), 8'hFF, 1'b0, 1'b0);
    check("t1_lat_e2", 128'(m_axis_tvalid), 128'(1));
    check("t1_first_data", 128'(m_axis_tdata), 128'(64'h0001_C0DE_0000_0000));
    beat(mk(2, 2), 8'h0F, 1'b1, 1'b0);
    vcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_axis_tvalid)
        vcnt++;
    end
    check("t1_no_bubble", 128'(vcnt), 128'(10));
    @(negedge clk);
    check("t1_end_valid", 128'(m_axis_tvalid), 128'(0));
    check("t1_frames", 128'(o_frame_cnt), 128'(2));
    tick();

    // Errored frame followed by a good one.
    do_reset();
    x0 = xfers;
    frame(3, 3, 1'b1);
    check("t2_drop_pulse", 128'(o_drop), 128'(1));
    check("t2_drop_cnt", 128'(o_drop_cnt), 128'(1));
    frame(4, 4, 1'b0);
    drain();
    check("t2_out_beats", 128'(xfers - x0), 128'(4));
    check("t2_frames", 128'(o_frame_cnt), 128'(1));

    // Overflow with a stalled output: 7th beat of second frame drops.
    do_reset();
    m_axis_tready = 1'b0;
    x0 = xfers;
    frame(5, 10, 1'b0);
    for (int i = 0; i < 10; i++) begin
      beat(mk(6, i), 8'hFF, i == 9, 1'b0);
      if (i == 5)
        check("t3_no_drop_b6", 128'(o_drop), 128'(0));
      if (i == 6)
        check("t3_drop_b7", 128'(o_drop), 128'(1));
    end
    check("t3_drop_cnt", 128'(o_drop_cnt), 128'(1));
    check("t3_frames", 128'(o_frame_cnt), 128'(1));
    drain();
    check("t3_out_beats", 128'(xfers - x0), 128'(10));

    // Oversized frame stays in DROP until its tlast.
    do_reset();
    m_axis_tready = 1'b1;
    x0 = xfers;
    for (int i = 0; i < 20; i++) begin
      beat(mk(7, i), 8'hFF, i == 19, 1'b0);
      if (i == 15)
        check("t4_no_drop_b16", 128'(o_drop), 128'(0));
      if (i == 16)
        check("t4_drop_b17", 128'(o_drop), 128'(1));
    end
    repeat (4) tick();
    check("t4_frames", 128'(o_frame_cnt), 128'(0));
    check("t4_drop_cnt", 128'(o_drop_cnt), 128'(1));
    check("t4_out_beats", 128'(xfers - x0), 128'(0));
    frame(8, 2, 1'b0);
    drain();
    check("t4_recover", 128'(xfers - x0), 128'(2));

    // Reset while a frame is streaming out.
    do_reset();
    m_axis_tready = 1'b1;
    frame(9, 8, 1'b0);
    t = 0;
    while (!m_axis_tvalid && t < 10) begin
      tick();
      t++;
    end
    check("t5_valid_seen", 128'(m_axis_tvalid), 128'(1));
    tick();
    do_reset();
    x0 = xfers;
    frame(10, 5, 1'b0);
    drain();
    check("t5_out_beats", 128'(xfers - x0), 128'(5));
    check("t5_frames", 128'(o_frame_cnt), 128'(1));

    // 1000 good frames with random output stalls.
    do_reset();
    rnd_ready = 1;
    for (int f = 0; f < 1000; f++) begin
      n = $urandom_range(1, 8);
      t = 0;
      while ((exp_q.size() + part_q.size()) > DEPTH - 8 && t < 500) begin
        tick();
        t++;
      end
      check("t6_pace", 128'(t < 500), 128'(1));
      for (int i = 0; i < n; i++)
        beat({$urandom, $urandom}, 8'($urandom), i == n - 1, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    check("t6_frames", 128'(o_frame_cnt), 128'(1000));
    check("t6_drops", 128'(o_drop_cnt), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
